// File: rtl/nw_align_emitter.sv
// nw_align_emitter
// Turns the Needleman-Wunsch traceback coordinate stream, which runs from the
// string end back to (0,0), into alignment columns. The columns are stacked in
// a LIFO and then replayed in forward order on a valid/ready stream.
// Build option: define NW_SCORE_CHECK_EN to recompute the alignment score on
// score_chk. When it is not defined, score_chk is tied to zero.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// IDLE     | waiting for the first record of a path
// CAPTURE  | classifying each step and pushing the column of the previous cell
// FLUSH    | the origin has arrived; the terminal (0,0) column goes out first
// EMIT     | popping the LIFO onto the output stream
// ERR      | protocol error; everything is frozen until reset

module nw_align_emitter #(
   parameter int LENGTH      = 10,
   parameter int CWIDTH      = 2,
   parameter int SWIDTH      = 16,
   parameter int CORD_LENGTH = 8,
   parameter int MATCH       = 1,
   parameter int INDEL       = -1,
   parameter int MISMATCH    = -1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [LENGTH*CWIDTH-1:0] s1,
   input  logic [LENGTH*CWIDTH-1:0] s2,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [CORD_LENGTH-1:0]   in_x,
   input  logic [CORD_LENGTH-1:0]   in_y,
   input  logic                     in_last,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [CWIDTH-1:0]        out_c1,
   output logic [CWIDTH-1:0]        out_c2,
   output logic                     out_gap1,
   output logic                     out_gap2,
   output logic                     out_last,
   output logic                     done,
   output logic                     err,
   output logic [SWIDTH-1:0]        score_chk
);

   localparam int DEPTH = 2 * LENGTH;
   localparam int PW    = $clog2(DEPTH) + 1;
   localparam int AW    = PW - 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CAPTURE,
      S_FLUSH,
      S_EMIT,
      S_ERR
   } state_t;

   typedef struct packed {
      logic [CWIDTH-1:0] c1;
      logic [CWIDTH-1:0] c2;
      logic              g1;
      logic              g2;
   } col_t;

   // An index that lies past the string end reads as character 0. This keeps
   // the select free of X values when a malformed path is being rejected.
   function automatic logic [CWIDTH-1:0] char_at(input logic [LENGTH*CWIDTH-1:0] s,
                                                 input logic [CORD_LENGTH-1:0]   idx);
      logic [CWIDTH-1:0] c;
      c = '0;
      for (int j = 0; j < LENGTH; j++) begin
         if (idx == CORD_LENGTH'(j)) c = s[j*CWIDTH +: CWIDTH];
      end
      return c;
   endfunction

   state_t                 state_q;
   logic                   in_ready_q;
   logic                   out_valid_q;
   col_t                   out_col_q;
   logic                   out_last_q;
   logic                   done_q;
   logic                   err_q;
   logic [PW-1:0]          ptr_q;
   logic [CORD_LENGTH-1:0] prev_x_q;
   logic [CORD_LENGTH-1:0] prev_y_q;
   col_t                   lifo_q [0:DEPTH-1];

   logic                   in_acc;
   logic                   lifo_full;
   logic                   cur_origin;
   logic                   step_ok;
   logic                   push_step;
   logic                   push_term;
   logic                   first_acc;
   logic [CORD_LENGTH-1:0] dx_d;
   logic [CORD_LENGTH-1:0] dy_d;
   logic [AW-1:0]          top_idx_d;
   col_t                   step_col_d;
   col_t                   term_col_d;

   // Classify the step from the previous cell to the incoming cell, then build the column for the previous cell.
   always_comb begin
      in_acc     = in_valid && in_ready_q;
      lifo_full  = (ptr_q == PW'(DEPTH));
      cur_origin = (in_x == '0) && (in_y == '0);
      dx_d       = prev_x_q - in_x;
      dy_d       = prev_y_q - in_y;
      step_col_d = '0;
      step_ok    = 1'b0;
      if (dx_d == CORD_LENGTH'(1) && dy_d == CORD_LENGTH'(1)) begin
         step_ok       = 1'b1;
         step_col_d.c1 = char_at(s1, prev_y_q);
         step_col_d.c2 = char_at(s2, prev_x_q);
      end else if (dx_d == '0 && dy_d == CORD_LENGTH'(1)) begin
         step_ok       = 1'b1;
         step_col_d.c1 = char_at(s1, prev_y_q);
         step_col_d.g2 = 1'b1;
      end else if (dx_d == CORD_LENGTH'(1) && dy_d == '0) begin
         step_ok       = 1'b1;
         step_col_d.g1 = 1'b1;
         step_col_d.c2 = char_at(s2, prev_x_q);
      end
      term_col_d    = '0;
      term_col_d.c1 = s1[CWIDTH-1:0];
      term_col_d.c2 = s2[CWIDTH-1:0];
      push_step     = (state_q == S_CAPTURE) && in_acc && step_ok && !lifo_full;
      push_term     = (state_q == S_FLUSH) && !lifo_full;
      first_acc     = (state_q == S_IDLE) && in_acc;
      top_idx_d     = AW'(ptr_q - PW'(1));
   end

   // LIFO storage. The terminal column is never stored; FLUSH sends it straight to the output register.
   always_ff @(posedge clk) begin
      if (push_step) lifo_q[ptr_q[AW-1:0]] <= step_col_d;
   end

   // Sequencing FSM with registered handshake, output data, done and err.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_col_q   <= '0;
         out_last_q  <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         ptr_q       <= '0;
         prev_x_q    <= '0;
         prev_y_q    <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               in_ready_q <= 1'b1;
               if (in_acc) begin
                  prev_x_q <= in_x;
                  prev_y_q <= in_y;
                  ptr_q    <= '0;
                  if (!in_last) begin
                     state_q <= S_CAPTURE;
                  end else begin
                     in_ready_q <= 1'b0;
                     if (cur_origin) begin
                        state_q <= S_FLUSH;
                     end else begin
                        state_q <= S_ERR;
                        err_q   <= 1'b1;
                     end
                  end
               end
            end
            S_CAPTURE: begin
               if (in_acc) begin
                  prev_x_q <= in_x;
                  prev_y_q <= in_y;
                  if (!step_ok || lifo_full) begin
                     state_q    <= S_ERR;
                     err_q      <= 1'b1;
                     in_ready_q <= 1'b0;
                  end else begin
                     ptr_q <= ptr_q + PW'(1);
                     if (in_last) begin
                        in_ready_q <= 1'b0;
                        if (cur_origin) begin
                           state_q <= S_FLUSH;
                        end else begin
                           state_q <= S_ERR;
                           err_q   <= 1'b1;
                        end
                     end
                  end
               end
            end
            S_FLUSH: begin
               if (lifo_full) begin
                  state_q <= S_ERR;
                  err_q   <= 1'b1;
               end else begin
                  out_col_q   <= term_col_d;
                  out_valid_q <= 1'b1;
                  out_last_q  <= (ptr_q == '0);
                  state_q     <= S_EMIT;
               end
            end
            S_EMIT: begin
               if (out_valid_q && out_ready) begin
                  if (out_last_q) begin
                     out_valid_q <= 1'b0;
                     out_last_q  <= 1'b0;
                     done_q      <= 1'b1;
                     in_ready_q  <= 1'b1;
                     state_q     <= S_IDLE;
                  end else begin
                     out_col_q  <= lifo_q[top_idx_d];
                     out_last_q <= (ptr_q == PW'(1));
                     ptr_q      <= ptr_q - PW'(1);
                  end
               end
            end
            S_ERR: begin
               in_ready_q  <= 1'b0;
               out_valid_q <= 1'b0;
               err_q       <= 1'b1;
            end
            default: begin
               state_q     <= S_ERR;
               err_q       <= 1'b1;
               in_ready_q  <= 1'b0;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_c1    = out_col_q.c1;
   assign out_c2    = out_col_q.c2;
   assign out_gap1  = out_col_q.g1;
   assign out_gap2  = out_col_q.g2;
   assign out_last  = out_last_q;
   assign done      = done_q;
   assign err       = err_q;

`ifdef NW_SCORE_CHECK_EN
   function automatic logic [SWIDTH-1:0] col_weight(input col_t c);
      if (c.g1 || c.g2)  return SWIDTH'(INDEL);
      if (c.c1 == c.c2)  return SWIDTH'(MATCH);
      return SWIDTH'(MISMATCH);
   endfunction

   logic [SWIDTH-1:0] score_q;

   // Running score over every pushed column. It holds after done until the next path starts.
   always_ff @(posedge clk) begin
      if (reset) begin
         score_q <= '0;
      end else if (first_acc) begin
         score_q <= '0;
      end else if (push_step) begin
         score_q <= score_q + col_weight(step_col_d);
      end else if (push_term) begin
         score_q <= score_q + col_weight(term_col_d);
      end
   end

   assign score_chk = score_q;
`else
   logic score_unused;
   assign score_unused = (MATCH != 0) ^ (INDEL != 0) ^ (MISMATCH != 0) ^ first_acc ^ push_term;
   assign score_chk    = '0;
`endif

endmodule

// File: tb/tb_nw_align_emitter.sv
// Bench for nw_align_emitter (LENGTH=4). A path-level model turns each coordinate
// list into the forward-ordered columns and the score. A negedge monitor
// compares every visible output column and the done pulse against that model.
module tb_nw_align_emitter;
   localparam int L  = 4;
   localparam int CW = 2;
   localparam int SW = 16;
   localparam int CL = 8;
   localparam int W_MATCH = 1, W_INDEL = -1, W_MISMATCH = -1;
`ifdef NW_SCORE_CHECK_EN
   localparam bit SCORE_EN = 1'b1;
`else
   localparam bit SCORE_EN = 1'b0;
`endif

   typedef struct packed {
      logic [CW-1:0] c1;
      logic [CW-1:0] c2;
      logic          g1;
      logic          g2;
      logic          last;
   } col_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [L*CW-1:0] s1 = '0, s2 = '0;
   logic          in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
   logic [CL-1:0] in_x = '0, in_y = '0;
   logic          in_ready, out_valid, out_gap1, out_gap2, out_last, done, err;
   logic [CW-1:0] out_c1, out_c2;
   logic [SW-1:0] score_chk;

   nw_align_emitter #(.LENGTH(L), .CWIDTH(CW), .SWIDTH(SW), .CORD_LENGTH(CL),
                      .MATCH(W_MATCH), .INDEL(W_INDEL), .MISMATCH(W_MISMATCH)) dut (
      .clk(clk), .reset(reset), .s1(s1), .s2(s2),
      .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_c1(out_c1), .out_c2(out_c2),
      .out_gap1(out_gap1), .out_gap2(out_gap2), .out_last(out_last),
      .done(done), .err(err), .score_chk(score_chk));

   always #5 clk = ~clk;

   int n_cmp = 0, n_bad = 0;
   int rx[$], ry[$];
   col_t exp_q[$], got_q[$];
   logic [SW-1:0] exp_score = '0;
   int done_cnt = 0;
   bit done_exp = 1'b0;
   int rdy_mode = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [CW-1:0] ch(input logic [L*CW-1:0] s, input int j);
      logic [L*CW-1:0] t;
      t = s >> (j * CW);
      return t[CW-1:0];
   endfunction

   // Path model: walk the steps, then reverse the columns. Returns 0 when the path is illegal.
   function automatic bit build_model();
      col_t back[$];
      col_t c;
      int sc, n, dx, dy;
      sc = 0;
      n = rx.size();
      exp_q.delete();
      if (rx[n-1] != 0 || ry[n-1] != 0) return 1'b0;
      for (int i = 0; i < n - 1; i++) begin
         dx = rx[i] - rx[i+1];
         dy = ry[i] - ry[i+1];
         c = '0;
         if (dx == 1 && dy == 1) begin
            c.c1 = ch(s1, ry[i]); c.c2 = ch(s2, rx[i]);
            sc += (c.c1 == c.c2) ? W_MATCH : W_MISMATCH;
         end else if (dx == 0 && dy == 1) begin
            c.c1 = ch(s1, ry[i]); c.g2 = 1'b1; sc += W_INDEL;
         end else if (dx == 1 && dy == 0) begin
            c.c2 = ch(s2, rx[i]); c.g1 = 1'b1; sc += W_INDEL;
         end else begin
            return 1'b0;
         end
         back.push_back(c);
      end
      c = '0;
      c.c1 = ch(s1, 0); c.c2 = ch(s2, 0);
      sc += (c.c1 == c.c2) ? W_MATCH : W_MISMATCH;
      c.last = (back.size() == 0);
      exp_q.push_back(c);
      for (int i = back.size() - 1; i >= 0; i--) begin
         c = back[i];
         c.last = (i == 0);
         exp_q.push_back(c);
      end
      exp_score = SCORE_EN ? SW'(sc) : '0;
      return 1'b1;
   endfunction

   // Per-cycle compare of the output stream and the done pulse.
   always @(negedge clk) begin
      col_t a;
      if (reset) begin
         done_exp = 1'b0;
      end else begin
         chk("done", done, done_exp);
         if (done) begin
            done_cnt++;
            chk("score_chk", score_chk, exp_score);
         end
         if (out_valid) begin
            a = '{c1: out_c1, c2: out_c2, g1: out_gap1, g2: out_gap2, last: out_last};
            if (exp_q.size() == 0) begin
               chk("extra_col", out_valid, 1'b0);
            end else begin
               chk("col", 32'(a), 32'(exp_q[0]));
               if (out_ready) begin
                  got_q.push_back(a);
                  void'(exp_q.pop_front());
               end
            end
         end
         done_exp = out_valid && out_ready && out_last;
      end
   end

   // out_ready pattern generator: 0 always, 1 pattern 1,0,0,1, 2 random, 3 stalled.
   initial begin
      int k;
      bit pat[4];
      pat = '{1'b1, 1'b0, 1'b0, 1'b1};
      k = 0;
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = pat[k % 4];
            2: out_ready = 1'($urandom_range(1, 0));
            default: out_ready = 1'b0;
         endcase
         k++;
      end
   end

   task automatic send_rec(input int x, input int y, input bit last, input int bound, output bit acc);
      int t;
      t = 0;
      acc = 1'b0;
      in_valid = 1'b1; in_x = CL'(x); in_y = CL'(y); in_last = last;
      while (!acc && t < bound) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk); #1;
         t++;
      end
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      exp_q.delete();
      @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", {out_c1, out_c2, out_gap1, out_gap2, out_last}, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_score", score_chk, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rdy_low_after_rst", in_ready, 0);
      @(negedge clk);
      chk("rdy_rise_after_rst", in_ready, 1);
      @(posedge clk); #1;
   endtask

   task automatic run_path(input string name, input int rmode, input int maxgap);
      bit legal, acc;
      int t, d0, n;
      rdy_mode = rmode;
      legal = build_model();
      got_q.delete();
      d0 = done_cnt;
      n = rx.size();
      for (int i = 0; i < n; i++) begin
         send_rec(rx[i], ry[i], (i == n - 1), 20, acc);
         if (!acc) begin
            if (legal) chk({name, "_accept"}, 0, 1);
            break;
         end
         if (i < n - 1) repeat ($urandom_range(maxgap, 0)) begin @(posedge clk); #1; end
      end
      if (legal) begin
         @(negedge clk);
         chk({name, "_flush_rdy"}, in_ready, 0);
         chk({name, "_flush_valid"}, out_valid, 0);
         @(negedge clk);
         chk({name, "_first_valid"}, out_valid, 1);
         t = 0;
         while (done_cnt == d0 && t < 400) begin @(negedge clk); #1; t++; end
         chk({name, "_rdy_at_done"}, in_ready, 1);
         repeat (3) @(negedge clk);
         #1;
         chk({name, "_done_once"}, done_cnt - d0, 1);
         chk({name, "_cols_left"}, exp_q.size(), 0);
      end else begin
         repeat (2) @(negedge clk);
         for (int k = 0; k < 4; k++) begin
            chk({name, "_err"}, err, 1);
            chk({name, "_rdy_low"}, in_ready, 0);
            @(negedge clk);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic gen_path();
      int x, y, r;
      x = L - 1; y = L - 1;
      rx.delete(); ry.delete();
      rx.push_back(x); ry.push_back(y);
      while (x != 0 || y != 0) begin
         r = $urandom_range(2, 0);
         if (x == 0) r = 1;
         if (y == 0) r = 2;
         if (r == 0) begin x--; y--; end
         else if (r == 1) y--;
         else x--;
         rx.push_back(x); ry.push_back(y);
      end
   endtask

   initial begin
      bit acc;
      s1 = 8'hE4; s2 = 8'hE4;
      repeat (2) @(posedge clk); #1;
      do_reset();

      // All-diagonal path on identical strings.
      rx = '{3, 2, 1, 0}; ry = '{3, 2, 1, 0};
      run_path("diag", 0, 0);
      chk("diag_ncols", got_q.size(), 4);
      if (got_q.size() == 4)
         for (int i = 0; i < 4; i++)
            chk("diag_col_lit", 32'(got_q[i]), 32'({2'(i), 2'(i), 2'b00, (i == 3)}));
      chk("diag_score_lit", score_chk, SCORE_EN ? 16'd4 : 16'd0);

      // Mixed path containing a top step and a left step.
      s2 = 8'h1B;
      rx = '{3, 2, 1, 0, 0}; ry = '{3, 3, 2, 1, 0};
      run_path("mixed", 0, 1);
      chk("mixed_ncols", got_q.size(), 5);
      if (got_q.size() == 5) begin
         chk("mixed_col0", 32'(got_q[0]), 32'({2'd0, 2'd3, 3'b000}));
         chk("mixed_col1", 32'(got_q[1]), 32'({2'd1, 2'd0, 3'b010}));
         chk("mixed_col2", 32'(got_q[2]), 32'({2'd2, 2'd2, 3'b000}));
         chk("mixed_col3", 32'(got_q[3]), 32'({2'd3, 2'd1, 3'b000}));
         chk("mixed_col4", 32'(got_q[4]), 32'({2'd0, 2'd0, 3'b101}));
      end
      chk("mixed_score_lit", score_chk, SCORE_EN ? 16'hFFFD : 16'd0);

      // Stalled output with the 1,0,0,1 ready pattern.
      s2 = 8'hE4;
      rx = '{3, 2, 1, 0}; ry = '{3, 2, 1, 0};
      run_path("stall", 1, 0);
      chk("stall_ncols", got_q.size(), 4);

      // Single origin record sent while in IDLE.
      rx = '{0}; ry = '{0};
      run_path("single", 2, 0);
      chk("single_ncols", got_q.size(), 1);

      // Illegal step (3,3) -> (1,3).
      rx = '{3, 1}; ry = '{3, 3};
      run_path("illegal", 0, 0);
      do_reset();

      // in_last on a record that is not the origin.
      rx = '{1}; ry = '{0};
      run_path("last_10", 0, 0);
      do_reset();

      // Reset after 2 of 4 records, then a fresh path.
      rx = '{3, 2, 1, 0}; ry = '{3, 2, 1, 0};
      void'(build_model());
      send_rec(3, 3, 1'b0, 20, acc);
      send_rec(2, 2, 1'b0, 20, acc);
      do_reset();
      run_path("after_rst", 0, 0);
      chk("after_rst_ncols", got_q.size(), 4);

      // Reset while output is stalled, then a fresh path.
      rx = '{3, 2, 1, 0}; ry = '{3, 2, 1, 0};
      void'(build_model());
      rdy_mode = 3;
      for (int i = 0; i < 4; i++) send_rec(rx[i], ry[i], (i == 3), 20, acc);
      repeat (3) @(negedge clk);
      chk("abort_valid", out_valid, 1);
      @(posedge clk); #1;
      do_reset();
      run_path("after_abort", 0, 0);

      // Random strings, paths, gaps and ready patterns.
      for (int it = 0; it < 40; it++) begin
         s1 = L*CW'($urandom);
         s2 = L*CW'($urandom);
         if ($urandom_range(7, 0) == 0) begin
            rx = '{0}; ry = '{0};
         end else begin
            gen_path();
         end
         run_path("rand", $urandom_range(2, 0), $urandom_range(2, 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1);
   end
endmodule

// File: doc/nw_align_emitter.md
# nw_align_emitter

Downstream stage of the Needleman-Wunsch grid. Consumes the traceback coordinate stream the grid produces (one (x,y) cell per record, ordered from (LENGTH-1,LENGTH-1) back to (0,0)). Converts each step into an alignment column (character pair or character/gap) and buffers the columns in a LIFO. Replays them in forward order (string start first) on a valid/ready output stream.

## Interface
Parameters:
- LENGTH, 10, characters per string
- CWIDTH, 2, bits per character
- SWIDTH, 16, bits per score
- CORD_LENGTH, 8, bits per coordinate
- MATCH, 1, signed match weight (used only with score check)
- INDEL, -1, signed gap weight (used only with score check)
- MISMATCH, -1, signed mismatch weight (used only with score check)

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- s1  in  LENGTH*CWIDTH  string 1, char j at s1[j*CWIDTH +: CWIDTH], indexed by y; stable from first accept to done
- s2  in  LENGTH*CWIDTH  string 2, char k at s2[k*CWIDTH +: CWIDTH], indexed by x
- in_valid  in  1  coordinate record valid
- in_ready  out  1  record accepted when in_valid && in_ready
- in_x, in_y  in  CORD_LENGTH each  cell coordinate
- in_last  in  1  marks final record; must accompany (0,0)
- out_valid  out  1  column valid
- out_ready  in  1  column consumed when out_valid && out_ready
- out_c1, out_c2  out  CWIDTH each  characters; 0 when corresponding gap bit is set
- out_gap1, out_gap2  out  1 each  gap in string 1 / string 2
- out_last  out  1  final column
- done  out  1  one-cycle pulse after final column consumed
- err  out  1  sticky protocol error
- score_chk  out  SWIDTH  signed recomputed score (NW_SCORE_CHECK_EN only)

## Operation
- States: IDLE, CAPTURE, FLUSH, EMIT, ERR.
- IDLE: in_ready=1. Accepted record is latched as prev; go CAPTURE. A record with in_last in IDLE goes directly to FLUSH.
- CAPTURE: in_ready=1. On accept of cur, classify prev to cur and push the column for prev:
  - (dx,dy)=(1,1): diagonal; pair s1[prev.y], s2[prev.x].
  - (0,1): top; s1[prev.y], gap2=1.
  - (1,0): left; gap1=1, s2[prev.x].
  - Any other delta: err=1, go ERR.
  - Then prev<=cur. If cur has in_last: if cur != (0,0), go ERR; else go FLUSH.
- FLUSH: in_ready=0. Push terminal column s1[0],s2[0] (diagonal). Go EMIT.
- EMIT: in_ready=0. Pop LIFO top to the output. out_last=1 when one entry remains. After the last pop, pulse done and return to IDLE.
- ERR: in_ready=0, out_valid=0. Held until reset.
- LIFO: depth 2*LENGTH, pointer width clog2(2*LENGTH)+1. A push when full sets err and goes to ERR.
- Valid paths never exceed 2*LENGTH-1 columns.
- Reset values: in_ready=0, out_valid=0, out_c1/out_c2/out_gap1/out_gap2/out_last=0, done=0, err=0, score_chk=0. LIFO is emptied and state is IDLE.
- in_ready rises the cycle after reset deasserts.
- Reset asserted mid-capture or mid-emit discards all buffered columns.

## Timing
- in_ready is a registered function of state. It is deasserted in the cycle after the in_last accept, so back-to-back records are accepted at 1/cycle.
- Column push for record i occurs in the cycle record i+1 is accepted. The terminal push occurs in FLUSH, one cycle after the last accept.
- The first out_valid is asserted 2 cycles after the in_last accept (FLUSH, then EMIT).
- Output data is registered. Output data holds stable while out_valid && !out_ready.
- Throughput is 1 column/cycle when out_ready=1.
- done is asserted in the cycle after the final handshake. in_ready returns the same cycle.
- An in_last record in IDLE is legal only at (0,0); it yields a single column.

## Configuration
- NW_SCORE_CHECK_EN defined: the block keeps a signed SWIDTH accumulator, cleared on the first accept.
  - Each pushed column adds MATCH (equal pair), MISMATCH (unequal pair) or INDEL (either gap).
  - score_chk is registered and valid while done is asserted; it holds until the next first accept.
- NW_SCORE_CHECK_EN undefined: the accumulator is absent and score_chk is tied to 0.

## Test plan
- LENGTH=4, s1=s2=chars {0,1,2,3}, path (3,3),(2,2),(1,1),(0,0): the block emits 4 columns (0,0),(1,1),(2,2),(3,3) with no gaps. out_last is set on the 4th column, then done, and score_chk=4.
- LENGTH=4, path (3,3),(2,3),(1,2),(0,1),(0,0): the block emits (s1[0],s2[0]), (s1[1],gap), (s1[2],s2[1]), (s1[3],s2[2]), (gap,s2[3]). score_chk equals 2*INDEL plus the pair weights.
- Same as case 1 with out_ready toggled 1,0,0,1 repeatedly: the output stays stable while stalled, no column is lost or duplicated, and done is pulsed once.
- Illegal step (3,3) followed by (1,3): err=1 and in_ready=0 are sticky until reset, and no out_valid is asserted.
- Reset pulsed after 2 of 4 records: all outputs are at reset values next cycle. A fresh 4-record path then runs to completion correctly.
- in_last at (1,0): err=1.
